// File: rtl/pc_pkg.sv
// Shared types and defaults for the IF-stage program counter unit.
// pc_state_t is the capture FSM state; pc_src_t names the next-PC source.
package pc_pkg;

  localparam int          DEF_XLEN         = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEF_INST_BYTES   = 4;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    PEND_RED  = 2'd1,
    PEND_TRAP = 2'd2
  } pc_state_t;

  typedef enum logic [2:0] {
    SRC_TRAP  = 3'd0,
    SRC_PTRAP = 3'd1,
    SRC_RED   = 3'd2,
    SRC_PRED  = 3'd3,
    SRC_SEQ   = 3'd4
  } pc_src_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux and redirect alignment check.
// Priority: trap now > pending trap > aligned redirect now > pending redirect > PC+INST_BYTES.
// A redirect that coincides with a trap is discarded and never flagged as misaligned.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int INST_BYTES = DEF_INST_BYTES
) (
  input  pc_state_t       i_state,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pend_target,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_target,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_target,
  output logic [XLEN-1:0] o_next_pc,
  output pc_src_t         o_src,
  output logic [XLEN-1:0] o_pc_plus_inc,
  output logic [XLEN-1:0] o_trap_aligned,
  output logic            o_red_ok,
  output logic            o_red_misalign
);

  logic [XLEN-1:0] w_low_mask;
  logic            w_red_low_set;

  assign w_low_mask     = XLEN'(INST_BYTES - 1);
  assign w_red_low_set  = |(i_redirect_target & w_low_mask);
  assign o_pc_plus_inc  = i_pc + XLEN'(INST_BYTES);
  assign o_trap_aligned = i_trap_target & ~w_low_mask;
  assign o_red_ok       = i_redirect_valid & ~i_trap_valid & ~w_red_low_set;
  assign o_red_misalign = i_redirect_valid & ~i_trap_valid &  w_red_low_set;

  // Fixed-priority source selection for the next fetch PC.
  always_comb begin
    o_src     = SRC_SEQ;
    o_next_pc = o_pc_plus_inc;
    if (i_trap_valid) begin
      o_src     = SRC_TRAP;
      o_next_pc = o_trap_aligned;
    end else if (i_state == PEND_TRAP) begin
      o_src     = SRC_PTRAP;
      o_next_pc = i_pend_target;
    end else if (o_red_ok) begin
      o_src     = SRC_RED;
      o_next_pc = i_redirect_target;
    end else if (i_state == PEND_RED) begin
      o_src     = SRC_PRED;
      o_next_pc = i_pend_target;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter with branch/trap redirect capture across stalls.
// Handshake: the PC advances only when pc_valid & pc_write & if_ready; while held,
// a redirect or trap is captured into a single pending slot (traps dominate,
// youngest redirect wins) and applied on the next advance.
// Optional performance counters are built when PC_UNIT_PERF_CNT_EN is defined.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int              INST_BYTES   = DEF_INST_BYTES  // power of two, >= 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            if_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            redirect_pending,
  output logic            misalign_err,
  output logic [1:0]      dbg_state
`ifdef PC_UNIT_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     redirect_cnt
`endif
);

  pc_state_t       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic [XLEN-1:0] r_pend_target;
  logic            r_misalign;

  logic            w_advance;
  logic [XLEN-1:0] w_next_pc;
  pc_src_t         w_src;
  logic [XLEN-1:0] w_trap_aligned;
  logic            w_red_ok;
  logic            w_red_misalign;

  assign w_advance        = r_pc_valid & pc_write & if_ready;
  assign pc_out           = r_pc;
  assign pc_valid         = r_pc_valid;
  assign redirect_pending = (r_state != RUN);
  assign misalign_err     = r_misalign;
  assign dbg_state        = r_state;

  pc_next_sel #(
    .XLEN       (XLEN),
    .INST_BYTES (INST_BYTES)
  ) u_next_sel (
    .i_state           (r_state),
    .i_pc              (r_pc),
    .i_pend_target     (r_pend_target),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .i_trap_valid      (trap_valid),
    .i_trap_target     (trap_target),
    .o_next_pc         (w_next_pc),
    .o_src             (w_src),
    .o_pc_plus_inc     (pc_plus_inc),
    .o_trap_aligned    (w_trap_aligned),
    .o_red_ok          (w_red_ok),
    .o_red_misalign    (w_red_misalign)
  );

  // PC register and pending-redirect capture FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_pc          <= RESET_VECTOR;
      r_pc_valid    <= 1'b0;
      r_pend_target <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_pc_valid <= 1'b1;
      r_misalign <= w_red_misalign;
      if (w_advance) begin
        r_pc    <= w_next_pc;
        r_state <= RUN;
      end else begin
        case (r_state)
          RUN, PEND_RED: begin
            if (trap_valid) begin
              r_state       <= PEND_TRAP;
              r_pend_target <= w_trap_aligned;
            end else if (w_red_ok) begin
              r_state       <= PEND_RED;
              r_pend_target <= redirect_target;
            end
          end
          PEND_TRAP: begin
            if (trap_valid) begin
              r_pend_target <= w_trap_aligned;
            end
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end

`ifdef PC_UNIT_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_redirect_cnt;

  assign fetch_cnt    = r_fetch_cnt;
  assign stall_cnt    = r_stall_cnt;
  assign redirect_cnt = r_redirect_cnt;

  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt    <= '0;
      r_stall_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (w_advance) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (r_pc_valid && !w_advance) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_advance && (w_src != SRC_SEQ)) r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule
